// File: rtl/mul_pkg.sv
// Shared sign-magnitude definitions for the ALU multiply/divide datapath.
// Holds field widths, the sign-bit index helper and the sequencer state type.
package mul_pkg;

    localparam int N_DEF      = 8;
    localparam int MAG_W      = N_DEF;
    localparam int OP_W       = N_DEF + 1;
    localparam int PROD_MAG_W = 2 * N_DEF;
    localparam int PROD_W     = 2 * N_DEF + 1;

    // The sign sits directly above the magnitude field.
    function automatic int sign_bit(input int mag_w);
        return mag_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiply_seq_if.sv
// Start/done handshake and sign-magnitude operand/product bus of the multiplier.
// The ALU controller drives through master; the multiplier sits on slave.
interface multiply_seq_if
    import mul_pkg::*;
#(
    parameter int N = N_DEF
);

    logic         start;
    logic [N:0]   X;
    logic [N:0]   Y;
    logic         busy;
    logic         done;
    logic [2*N:0] Prod;

    modport master (output start, output X, output Y,
                    input busy, input done, input Prod);
    modport slave  (input start, input X, input Y,
                    output busy, output done, output Prod);

endinterface

// File: rtl/multiply_seq.sv
// Sequential shift-add sign-magnitude multiplier, one partial product per clock.
// Optional build macro MUL_EARLY_EXIT_EN stops once the remaining multiplier bits are zero.
module multiply_seq
    import mul_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    multiply_seq_if.slave bus
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state, state_nx;
    logic [N-1:0]   mcand, mplier, mplier_nx;
    logic [2*N-1:0] acc, acc_nx, mag_nx;
    logic [N:0]     sum;
    logic [CW-1:0]  cnt;
    logic           sgn;
    logic [2*N:0]   prod;
    logic           accept, last_step, busy, done;

    // One add-shift step: the carry out of the upper half drops into the top bit.
    always_comb begin
        sum       = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
        acc_nx    = {sum, acc[N-1:1]};
        mplier_nx = {1'b0, mplier[N-1:1]};
`ifdef MUL_EARLY_EXIT_EN
        // Stopping early leaves the product high by the skipped shifts.
        last_step = (mplier_nx == '0) || (cnt == LAST);
        mag_nx    = acc_nx >> (LAST - cnt);
`else
        last_step = (cnt == LAST);
        mag_nx    = acc_nx;
`endif
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            prod   <= '0;
        end else if (accept) begin
            mcand  <= bus.X[N-1:0];
            mplier <= bus.Y[N-1:0];
            acc    <= '0;
            cnt    <= '0;
            sgn    <= bus.X[sign_bit(N)] ^ bus.Y[sign_bit(N)];
        end else if (state == RUN) begin
            acc    <= acc_nx;
            mplier <= mplier_nx;
            cnt    <= cnt + 1'b1;
            // A zero magnitude always reports positive, even for -0 operands.
            if (last_step) prod <= {sgn & (|mag_nx), mag_nx};
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.Prod = prod;

endmodule

// File: tb/tb_multiply_seq.sv
// Scoreboard bench for multiply_seq: directed and random operands against an arithmetic model.
module tb_multiply_seq;
    import mul_pkg::*;

    localparam int N = N_DEF;

    typedef struct {
        logic [2*N:0] prod;
        int           acc_edge;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    logic [2*N:0] last_prod = '0;

    multiply_seq_if #(.N(N)) bus ();
    multiply_seq #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [2*N:0] ref_prod(input logic [N:0] x, input logic [N:0] y);
        logic [2*N-1:0] m;
        m = (2*N)'(x[N-1:0]) * (2*N)'(y[N-1:0]);
        return {(x[N] ^ y[N]) && (m != 0), m};
    endfunction

    function automatic int ref_lat(input logic [N:0] y);
`ifdef MUL_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < N; i++) if (y[i]) l = i + 1;
        return l;
`else
        return N;
`endif
    endfunction

    task automatic push_exp(input logic [N:0] x, input logic [N:0] y, input int edge_no);
        exp_t e;
        e.prod = ref_prod(x, y);
        e.acc_edge = edge_no;
        e.lat = ref_lat(y);
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: done=1 with no request outstanding, Prod=0x%0h (cycle %0d)",
                         bus.Prod, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("prod", 64'(bus.Prod), 64'(e.prod));
                check("latency", 64'(cyc - e.acc_edge), 64'(e.lat));
                check("busy_at_done", 64'(bus.busy), 64'd0);
                last_prod = e.prod;
            end
        end
    end

    task automatic run_op(input logic [N:0] x, input logic [N:0] y, input bit repulse);
        int n;
        int busy_n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.X = x;
        bus.Y = y;
        push_exp(x, y, cyc + 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.X = $urandom();
        bus.Y = $urandom();
        check("prod_hold_in_run", 64'(bus.Prod), 64'(last_prod));
        n = 0;
        busy_n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            if (repulse && n == 2) begin
                bus.start = 1'b1;
                bus.X = ~x;
                bus.Y = {1'b0, ~y[N-1:0]};
            end
            if (repulse && n == 3) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(bus.done), 64'd1);
        check("busy_cycles", 64'(busy_n), 64'(ref_lat(y)));
    endtask

    task automatic wait_done(output int when);
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(bus.done), 64'd1);
        when = cyc;
    endtask

    initial begin
        int t1, t2;
        logic [N:0] rx, ry;
        bus.start = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_prod", 64'(bus.Prod), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(9'h003, 9'h005, 1'b0);
        run_op(9'h10C, 9'h00A, 1'b0);
        run_op(9'h0FF, 9'h1FF, 1'b0);
        run_op(9'h100, 9'h007, 1'b0);
        run_op(9'h07F, 9'h001, 1'b0);
        run_op(9'h1AB, 9'h000, 1'b0);
        run_op(9'h000, 9'h1FF, 1'b0);
        run_op(9'h155, 9'h185, 1'b1);
        repeat (3) @(negedge clk);
        check("prod_hold_idle", 64'(bus.Prod), 64'(last_prod));

        // start held high: second operation accepted in the DONE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.X = 9'h0C3;
        bus.Y = 9'h1A1;
        push_exp(9'h0C3, 9'h1A1, cyc + 1);
        wait_done(t1);
        bus.X = 9'h111;
        bus.Y = 9'h093;
        push_exp(9'h111, 9'h093, cyc + 1);
        @(negedge clk);
        wait_done(t2);
        bus.start = 1'b0;
        check("b2b_interval", 64'(t2 - t1), 64'(ref_lat(9'h093) + 1));

        // asynchronous abort mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.X = 9'h0EE;
        bus.Y = 9'h0F1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_prod", 64'(bus.Prod), 64'd0);
        last_prod = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(9'h0EE, 9'h0F1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rx = (N+1)'($urandom());
            ry = (N+1)'($urandom());
            if (i % 6 == 0) ry[N-1:N/2] = '0;
            run_op(rx, ry, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
